trig_timestamper: RTL

- Downstream consumer of the emulated trigger generator (emugen): timestamps every trigger rising edge relative to spill start, tags it with an event number and buffers the record in a small show-ahead FIFO.
- Readout logic drains the FIFO.
- Single clock domain, same clk as emugen; its trigger output connects directly to this block.

---
 rtl/trig_timestamper.sv | 131 +++++++++++++
 1 files changed

// File: rtl/trig_timestamper.sv
// trig_timestamper: timestamps trigger rising edges relative to spill start,
// tags each with an event number and queues {evt, timestamp} in a show-ahead
// FIFO for readout.
// Optional build macro: TRIG_DEADTIME_EN adds a post-trigger deadtime window
// of DEADTIME cycles during which further edges are silently discarded.
module trig_timestamper #(
  parameter int CNT_W    = 32,
  parameter int EVT_W    = 16,
  parameter int FIFO_AW  = 4,
  parameter int DEADTIME = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   trigger,
  input  logic                   rd_en,
  input  logic                   clr_ovf,
  output logic [EVT_W+CNT_W-1:0] dout,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic [15:0]            lost,
  output logic                   tsc_wrap
);

  localparam int REC_W = EVT_W + CNT_W;
  localparam int DEPTH = 2 ** FIFO_AW;

  logic               trig_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [EVT_W-1:0]   evt_q, evt_d;
  logic               wrap_q, wrap_d;
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        lost_q, lost_d;
  logic [REC_W-1:0]   mem_q [DEPTH];
  logic               trig_edge, edge_ok, do_wr, do_rd, drop;

  assign trig_edge = trigger & ~trig_q & enable;

`ifdef TRIG_DEADTIME_EN
  localparam int DT_W = $clog2(DEADTIME + 1);
  logic [DT_W-1:0] dt_q, dt_d;

  assign edge_ok = trig_edge & (dt_q == '0);

  // Deadtime window: reload on every processed edge, count down to zero.
  always_comb begin
    dt_d = dt_q;
    if (!enable)          dt_d = '0;
    else if (edge_ok)     dt_d = DT_W'(DEADTIME - 1);
    else if (dt_q != '0)  dt_d = dt_q - DT_W'(1);
  end

  // Deadtime counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dt_q <= '0;
    else        dt_q <= dt_d;
  end
`else
  assign edge_ok = trig_edge;
`endif

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

  // A pop in the same cycle frees the slot for a write into a full FIFO;
  // a pop of an empty FIFO is simply ignored.
  assign do_rd = rd_en & ~empty;
  assign do_wr = edge_ok & (~full | rd_en);
  assign drop  = edge_ok & full & ~rd_en;

  assign dout     = empty ? '0 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign overflow = ovf_q;
  assign lost     = lost_q;
  assign tsc_wrap = wrap_q;

  // Next-state for counters, pointers and drop bookkeeping.
  always_comb begin
    cnt_d    = enable ? cnt_q + CNT_W'(1) : '0;
    wrap_d   = enable & (&cnt_q);
    evt_d    = evt_q;
    if (!enable)      evt_d = '0;
    else if (edge_ok) evt_d = evt_q + EVT_W'(1);
    wr_ptr_d = wr_ptr_q + (FIFO_AW+1)'(do_wr);
    rd_ptr_d = rd_ptr_q + (FIFO_AW+1)'(do_rd);
    ovf_d    = ovf_q;
    lost_d   = lost_q;
    if (drop) begin
      // A drop coinciding with a clear restarts the count at one.
      ovf_d  = 1'b1;
      if (clr_ovf)      lost_d = 16'd1;
      else if (~&lost_q) lost_d = lost_q + 16'd1;
    end else if (clr_ovf) begin
      ovf_d  = 1'b0;
      lost_d = '0;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q   <= 1'b0;
      cnt_q    <= '0;
      evt_q    <= '0;
      wrap_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      lost_q   <= '0;
    end else begin
      trig_q   <= trigger;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
      wrap_q   <= wrap_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      lost_q   <= lost_d;
    end
  end

  // FIFO storage; records carry pre-increment evt and counter values.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {evt_q, cnt_q};
  end

endmodule
